// File: rtl/matrix_stream_loader_pkg.sv
// Shared constants and helpers for the matrix load/multiply/serialize path.
package matrix_stream_loader_pkg;

  localparam int WORD_W = 32;

  // Loader FSM encoding
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Counter width for n states; never narrower than one bit so a
  // degenerate 1-deep counter still has a real (constant-zero) register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Bit offset of element (r,c) inside a flat row-major matrix bus.
  function automatic int elem_off(input int r, input int c, input int cols);
    return WORD_W * (cols * r + c);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Two-level wrapping index counter: inner runs 0..INNER-1, outer advances
// on each inner wrap, and both wrap together after the last position.
module matrix_index_counter
  import matrix_stream_loader_pkg::*;
#(
  parameter int INNER = 1,
  parameter int OUTER = 1,
  localparam int IW   = clog2(INNER),
  localparam int OW   = clog2(OUTER)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clear,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);

  logic [IW-1:0] inner_q, inner_d;
  logic [OW-1:0] outer_q, outer_d;
  logic          inner_end, outer_end;

  assign inner_end = (inner_q == IW'(INNER - 1));
  assign outer_end = (outer_q == OW'(OUTER - 1));
  assign inner     = inner_q;
  assign outer     = outer_q;
  assign last      = inner_end && outer_end;

  // Next index: clear wins over increment, full wrap returns to origin
  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clear) begin
      inner_d = '0;
      outer_d = '0;
    end else if (inc) begin
      if (inner_end) begin
        inner_d = '0;
        outer_d = outer_end ? '0 : outer_q + OW'(1);
      end else begin
        inner_d = inner_q + IW'(1);
      end
    end
  end

  // Index registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects a stream of 32-bit words into a flat row-major matrix bus,
// optionally transposing a column-major stream, and holds it until the
// consumer takes it.
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int ROWS         = 1,
  parameter int COLS         = 1,
  parameter bit COL_MAJOR_IN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [WORD_W*ROWS*COLS-1:0]   matrix,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          len_err
);

  localparam int N     = ROWS * COLS;
  localparam int MAJ_N = COL_MAJOR_IN ? COLS : ROWS;
  localparam int MIN_N = COL_MAJOR_IN ? ROWS : COLS;
  localparam int IDXW  = clog2(N);
  localparam int MJW   = clog2(MAJ_N);
  localparam int MNW   = clog2(MIN_N);

  logic [0:0]                  state_q, state_d;
  logic                        len_err_q, len_err_d;
  logic [N-1:0][WORD_W-1:0]    mat_q, mat_d;
  logic [MJW-1:0]              maj_idx;
  logic [MNW-1:0]              min_idx;
  logic                        last_beat;
  logic                        accept;
  logic [IDXW-1:0]             idx;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_FULL);
  assign len_err   = len_err_q;
  assign accept    = in_valid && in_ready;

  // An early in_last restarts the count so the next matrix starts at (0,0)
  matrix_index_counter #(
    .INNER (MIN_N),
    .OUTER (MAJ_N)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clear (accept && in_last),
    .inner (min_idx),
    .outer (maj_idx),
    .last  (last_beat)
  );

  // Map the stream position onto a row-major element index
  always_comb begin
    int r_i, c_i;
    r_i = COL_MAJOR_IN ? int'(min_idx) : int'(maj_idx);
    c_i = COL_MAJOR_IN ? int'(maj_idx) : int'(min_idx);
    idx = IDXW'(COLS * r_i + c_i);
  end

  // Element write: only the addressed element changes, the rest hold
  always_comb begin
    mat_d = mat_q;
    for (int e = 0; e < N; e++) begin
      if (accept && (idx == IDXW'(e))) mat_d[e] = in_data;
    end
  end

  // LOAD/FULL sequencing and sticky length check
  always_comb begin
    state_d   = state_q;
    len_err_d = len_err_q;
    if (state_q == ST_LOAD) begin
      if (accept) begin
        if (in_last || last_beat) state_d = ST_FULL;
        if (in_last != last_beat) len_err_d = 1'b1;
      end
    end else if (out_ready) begin
      state_d = ST_LOAD;
    end
  end

  // State, error flag and matrix storage with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      len_err_q <= 1'b0;
      mat_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_err_q <= len_err_d;
      mat_q     <= mat_d;
    end
  end

  // Flatten storage onto the shared row-major bus layout
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign matrix[elem_off(r, c, COLS) +: WORD_W] = mat_q[r*COLS + c];
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench: a 2x3 row-major and a 2x3 column-major loader share one
// input stream; a 1x1 loader covers the degenerate case.
module tb_matrix_stream_loader;

  logic         clk, rst_n;
  logic [31:0]  in_data;
  logic         in_valid, in_last, out_ready;
  logic         rm_in_ready, rm_out_valid, rm_len_err;
  logic         cm_in_ready, cm_out_valid, cm_len_err;
  logic [191:0] rm_matrix, cm_matrix;
  logic         one_in_valid, one_out_ready;
  logic         one_in_ready, one_out_valid, one_len_err;
  logic [31:0]  one_matrix;

  logic [31:0]  exp_rm [6];
  logic [31:0]  exp_cm [6];
  int           k_pos;
  int           n_chk, n_fail;

  matrix_stream_loader #(.ROWS(2), .COLS(3), .COL_MAJOR_IN(1'b0)) u_rm (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rm_in_ready), .matrix(rm_matrix),
    .out_valid(rm_out_valid), .out_ready(out_ready), .len_err(rm_len_err));

  matrix_stream_loader #(.ROWS(2), .COLS(3), .COL_MAJOR_IN(1'b1)) u_cm (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(cm_in_ready), .matrix(cm_matrix),
    .out_valid(cm_out_valid), .out_ready(out_ready), .len_err(cm_len_err));

  matrix_stream_loader #(.ROWS(1), .COLS(1), .COL_MAJOR_IN(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(one_in_valid),
    .in_last(in_last), .in_ready(one_in_ready), .matrix(one_matrix),
    .out_valid(one_out_valid), .out_ready(one_out_ready), .len_err(one_len_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] pack_rm();
    logic [191:0] v;
    for (int e = 0; e < 6; e++) v[32*e +: 32] = exp_rm[e];
    return v;
  endfunction

  function automatic logic [191:0] pack_cm();
    logic [191:0] v;
    for (int e = 0; e < 6; e++) v[32*e +: 32] = exp_cm[e];
    return v;
  endfunction

  // Stream position k: row-major lands at element k; column-major stream
  // position k is (row = k%2, col = k/2) in a 2x3 matrix.
  task automatic model_accept(input logic [31:0] d, input logic l);
    exp_rm[k_pos] = d;
    exp_cm[(k_pos % 2) * 3 + k_pos / 2] = d;
    k_pos++;
    if (l || k_pos == 6) k_pos = 0;
  endtask

  task automatic model_clear();
    for (int e = 0; e < 6; e++) begin
      exp_rm[e] = '0;
      exp_cm[e] = '0;
    end
    k_pos = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int w;
    repeat (gap) tick();
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    w = 0;
    while (!rm_in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!rm_in_ready) begin
      chk("send_ready_timeout", 192'(rm_in_ready), 192'd1);
    end else begin
      tick();
      model_accept(d, l);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_mats(input string tag);
    chk({tag, "_rm"}, rm_matrix, pack_rm());
    chk({tag, "_cm"}, cm_matrix, pack_cm());
  endtask

  task automatic release_full();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    one_in_valid = 1'b0;
    out_ready = 1'b0;
    one_out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fl [6];
    logic [31:0] hold;
    int          hold_n;
    clk = 1'b0; rst_n = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; one_in_valid = 1'b0; one_out_ready = 1'b0;
    n_chk = 0; n_fail = 0;
    fl[0] = 32'h3F800000; fl[1] = 32'h40000000; fl[2] = 32'h40400000;
    fl[3] = 32'h40800000; fl[4] = 32'h40A00000; fl[5] = 32'h40C00000;

    // Reset state
    do_reset();
    chk("rst_out_valid", 192'(rm_out_valid), 192'd0);
    chk("rst_in_ready_rm", 192'(rm_in_ready), 192'd1);
    chk("rst_in_ready_cm", 192'(cm_in_ready), 192'd1);
    chk("rst_len_err", 192'(rm_len_err), 192'd0);
    check_mats("rst_mat");

    // Degenerate 1x1: every beat completes a matrix
    in_data = 32'hCAFE0001; in_last = 1'b1; one_in_valid = 1'b1;
    tick();
    one_in_valid = 1'b0; in_last = 1'b0;
    chk("one_out_valid", 192'(one_out_valid), 192'd1);
    chk("one_in_ready_full", 192'(one_in_ready), 192'd0);
    chk("one_matrix", 192'(one_matrix), 192'h00000000CAFE0001);
    chk("one_len_err0", 192'(one_len_err), 192'd0);
    one_out_ready = 1'b1;
    tick();
    one_out_ready = 1'b0;
    chk("one_in_ready_back", 192'(one_in_ready), 192'd1);
    in_data = 32'hCAFE0002; in_last = 1'b0; one_in_valid = 1'b1;
    tick();
    one_in_valid = 1'b0;
    chk("one_missing_last_err", 192'(one_len_err), 192'd1);
    chk("one_matrix2", 192'(one_matrix), 192'h00000000CAFE0002);

    // Full 6-beat load, 1.0..6.0
    for (int i = 0; i < 5; i++) send(fl[i], 1'b0, 0);
    chk("t1_not_yet_valid", 192'(rm_out_valid), 192'd0);
    send(fl[5], 1'b1, 0);
    chk("t1_out_valid_rm", 192'(rm_out_valid), 192'd1);
    chk("t1_out_valid_cm", 192'(cm_out_valid), 192'd1);
    chk("t1_in_ready", 192'(rm_in_ready), 192'd0);
    chk("t1_len_err", 192'({rm_len_err, cm_len_err}), 192'd0);
    chk("t1_rm_e00", 192'(rm_matrix[31:0]), 192'h3F800000);
    chk("t1_rm_e12", 192'(rm_matrix[32*5 +: 32]), 192'h40C00000);
    chk("t1_cm_e01", 192'(cm_matrix[32*1 +: 32]), 192'h40400000);
    chk("t1_cm_e10", 192'(cm_matrix[32*3 +: 32]), 192'h40000000);
    chk("t1_cm_e12", 192'(cm_matrix[32*5 +: 32]), 192'h40C00000);
    check_mats("t1_mat");

    // Back-pressure: beats offered while FULL must be ignored
    in_data = 32'hDEADBEEF; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", 192'(rm_in_ready), 192'd0);
      chk("bp_out_valid", 192'(rm_out_valid), 192'd1);
      check_mats("bp_mat");
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_full();
    chk("bp_release_in_ready", 192'(rm_in_ready), 192'd1);
    chk("bp_release_out_valid", 192'(cm_out_valid), 192'd0);
    check_mats("bp_release_mat");

    // Early in_last on beat 4 of 6
    send(32'h40E00000, 1'b0, 0);
    send(32'h41000000, 1'b0, 1);
    send(32'h41100000, 1'b0, 0);
    send(32'h41200000, 1'b1, 2);
    chk("early_len_err_rm", 192'(rm_len_err), 192'd1);
    chk("early_len_err_cm", 192'(cm_len_err), 192'd1);
    chk("early_out_valid", 192'(rm_out_valid), 192'd1);
    chk("early_rm_old_e4", 192'(rm_matrix[32*4 +: 32]), 192'h40A00000);
    chk("early_cm_new_e4", 192'(cm_matrix[32*4 +: 32]), 192'h41200000);
    check_mats("early_mat");
    release_full();
    for (int i = 0; i < 6; i++) send(32'h41300000 + 32'(i) * 32'h00100000, i == 5, 0);
    chk("second_out_valid", 192'(rm_out_valid), 192'd1);
    chk("second_rm_e5", 192'(rm_matrix[32*5 +: 32]), 192'h41800000);
    chk("second_len_err_sticky", 192'(rm_len_err), 192'd1);
    check_mats("second_mat");
    release_full();

    // Reset mid-load discards partial data and clears the error flag
    send(32'h11111111, 1'b0, 0);
    send(32'h22222222, 1'b0, 0);
    send(32'h33333333, 1'b0, 0);
    do_reset();
    chk("mid_rst_out_valid", 192'(rm_out_valid), 192'd0);
    chk("mid_rst_len_err", 192'({rm_len_err, cm_len_err}), 192'd0);
    chk("mid_rst_in_ready", 192'(rm_in_ready), 192'd1);
    check_mats("mid_rst_mat");
    for (int i = 0; i < 6; i++) send(fl[i], i == 5, 0);
    chk("reload_out_valid", 192'(rm_out_valid), 192'd1);
    chk("reload_len_err", 192'(rm_len_err), 192'd0);
    check_mats("reload_mat");
    release_full();

    // Missing in_last on the final beat
    for (int i = 0; i < 6; i++) send(32'hA0000000 + 32'(i), 1'b0, 0);
    chk("nolast_out_valid", 192'(rm_out_valid), 192'd1);
    chk("nolast_len_err", 192'({rm_len_err, cm_len_err}), 192'd3);
    check_mats("nolast_mat");
    release_full();

    // Random gaps and consumer back-pressure
    for (int m = 0; m < 100; m++) begin
      for (int b = 0; b < 6; b++) send($urandom, b == 5, $urandom_range(0, 2));
      chk("rnd_out_valid", 192'(rm_out_valid), 192'd1);
      check_mats("rnd_mat");
      hold_n = $urandom_range(0, 3);
      hold   = rm_matrix[31:0];
      repeat (hold_n) tick();
      chk("rnd_hold_valid", 192'(cm_out_valid), 192'd1);
      chk("rnd_hold_e0", 192'(rm_matrix[31:0]), 192'(exp_rm[0]));
      if (hold !== exp_rm[0]) chk("rnd_hold_stable", 192'(hold), 192'(exp_rm[0]));
      release_full();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
